// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width used by transmitter, receiver and feeder,
// plus the feeder FSM state type and a counter-width helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StWait = 2'd2,
        StGap  = 2'd3
    } feeder_state_e;

    // Bits needed for a counter that runs 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count,
// so a pop in the same cycle never frees space for a write.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly ADDR_W bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them one at a time to the UART transmitter.
// Define UART_TX_FEEDER_TIMEOUT_EN to add the done_tx watchdog and timeout port.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic [UART_DATA_W-1:0] din_tx,
    output logic                   data_update,
    input  logic                   done_tx,
    output logic                   busy
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    localparam int unsigned GapW = cnt_width(GAP_CYCLES);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    feeder_state_e          state_q;
    feeder_state_e          state_d;
    logic [GapW-1:0]        gap_q;
    logic [GapW-1:0]        gap_d;
    logic [UART_DATA_W-1:0] din_q;
    logic                   overflow_q;
    logic [UART_DATA_W-1:0] head;
    logic                   pop;

    // The head is popped on the IDLE->LOAD edge so din_tx is already valid in LOAD.
    assign pop = (state_q == StIdle) && !empty;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int unsigned ToW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0] ToLast =
        ToW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [ToW-1:0] wait_cnt_q;
    logic [ToW-1:0] wait_cnt_d;
    logic           timeout_q;
    logic           timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StWait;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StWait: begin
                if (done_tx) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                // A late done_tx on the expiry cycle still wins over the watchdog.
                else if (wait_cnt_q == ToLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            din_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            overflow_q <= wr_en && full;
            if (pop) begin
                din_q <= head;
            end
        end
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign din_tx      = din_q;
    assign data_update = (state_q == StLoad);
    assign busy        = (state_q != StIdle);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: one instance without gap, one with GAP_CYCLES=4 and
// TIMEOUT_CYCLES=20, checked each cycle against a queue-based model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en [2];
    logic [7:0] wr_data [2];
    logic       done_tx [2];
    logic       full [2];
    logic       empty [2];
    logic [4:0] level [2];
    logic       overflow [2];
    logic [7:0] din_tx [2];
    logic       data_update [2];
    logic       busy [2];
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic       timeout [2];
`endif

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (0)
    ) u_nogap (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en[0]),
        .wr_data     (wr_data[0]),
        .full        (full[0]),
        .empty       (empty[0]),
        .level       (level[0]),
        .overflow    (overflow[0]),
        .din_tx      (din_tx[0]),
        .data_update (data_update[0]),
        .done_tx     (done_tx[0]),
        .busy        (busy[0])
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        ,
        .timeout     (timeout[0])
`endif
    );

    uart_tx_feeder #(
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (20)
    ) u_gap (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en[1]),
        .wr_data     (wr_data[1]),
        .full        (full[1]),
        .empty       (empty[1]),
        .level       (level[1]),
        .overflow    (overflow[1]),
        .din_tx      (din_tx[1]),
        .data_update (data_update[1]),
        .done_tx     (done_tx[1]),
        .busy        (busy[1])
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        ,
        .timeout     (timeout[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: byte queues plus event times (when a byte was loaded, when the
    // feeder may load again) derived from the rules, not from any FSM encoding.
    int          gap_c [2] = '{0, 4};
    int          to_c [2]  = '{2000000, 20};
    logic [7:0]  mq0 [$];
    logic [7:0]  mq1 [$];
    bit          outst [2];
    int          load_cyc [2];
    int          idle_from [2];
    logic [7:0]  m_din [2];
    bit          m_du [2];
    bit          m_ovf [2];
    bit          m_to [2];
    int          m_lvl [2];
    bit          m_valid = 1'b0;
    int          cyc = 0;

    task automatic model_step(input int i);
        logic [7:0] q [$];
        int         prev_lvl;
        bit         du_n;
        if (i == 0) q = mq0; else q = mq1;
        if (rst) begin
            q.delete();
            outst[i]     = 1'b0;
            idle_from[i] = 0;
            m_din[i]     = 8'h00;
            m_du[i]      = 1'b0;
            m_ovf[i]     = 1'b0;
            m_to[i]      = 1'b0;
        end else begin
            prev_lvl = q.size();
            du_n     = !outst[i] && (cyc - 1 >= idle_from[i]) && (prev_lvl > 0);
            m_to[i]  = 1'b0;
            if (outst[i] && done_tx[i] && (cyc - 1 > load_cyc[i])) begin
                outst[i]     = 1'b0;
                idle_from[i] = cyc + gap_c[i];
            end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            else if (outst[i] && (cyc - 1 == load_cyc[i] + to_c[i])) begin
                outst[i]     = 1'b0;
                idle_from[i] = cyc;
                m_to[i]      = 1'b1;
            end
`endif
            m_ovf[i] = wr_en[i] && (prev_lvl == DEPTH);
            m_du[i]  = du_n;
            if (du_n) begin
                m_din[i]    = q.pop_front();
                outst[i]    = 1'b1;
                load_cyc[i] = cyc;
            end
            if (wr_en[i] && (prev_lvl < DEPTH)) q.push_back(wr_data[i]);
        end
        m_lvl[i] = q.size();
        if (i == 0) mq0 = q; else mq1 = q;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) m_valid = 1'b1;
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d.data_update", i), data_update[i], m_du[i]);
                    chk($sformatf("u%0d.din_tx", i), din_tx[i], m_din[i]);
                    chk($sformatf("u%0d.level", i), level[i], m_lvl[i]);
                    chk($sformatf("u%0d.full", i), full[i], m_lvl[i] == DEPTH);
                    chk($sformatf("u%0d.empty", i), empty[i], m_lvl[i] == 0);
                    chk($sformatf("u%0d.overflow", i), overflow[i], m_ovf[i]);
                    chk($sformatf("u%0d.busy", i), busy[i], outst[i] || (cyc < idle_from[i]));
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                    chk($sformatf("u%0d.timeout", i), timeout[i], m_to[i]);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [7:0] b);
        wr_en[i]   = 1'b1;
        wr_data[i] = b;
        tick();
        wr_en[i] = 1'b0;
    endtask

    task automatic done_pulse(input int i);
        done_tx[i] = 1'b1;
        tick();
        done_tx[i] = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = '{1'b0, 1'b0};
        wr_data    = '{8'h00, 8'h00};
        done_tx    = '{1'b0, 1'b0};
        repeat (3) tick();
        rst = 1'b0;
        chk("reset.empty", empty[0], 1'b1);
        chk("reset.full", full[0], 1'b0);
        chk("reset.level", level[0], 5'd0);
        chk("reset.busy", busy[0], 1'b0);
        chk("reset.data_update", data_update[0], 1'b0);
        chk("reset.din_tx", din_tx[0], 8'h00);
        chk("reset.overflow", overflow[1], 1'b0);
        repeat (2) tick();

        // Single byte: write at N, load at N+2
        wr(0, 8'hA5);
        chk("single.level_n1", level[0], 5'd1);
        chk("single.du_n1", data_update[0], 1'b0);
        tick();
        chk("single.du_n2", data_update[0], 1'b1);
        chk("single.din_n2", din_tx[0], 8'hA5);
        chk("single.busy_n2", busy[0], 1'b1);
        tick();
        chk("single.du_n3", data_update[0], 1'b0);
        repeat (30) tick();
        chk("single.wait_holds", busy[0], 1'b1);
        done_pulse(0);
        chk("single.busy_after_done", busy[0], 1'b0);
        chk("single.empty_after_done", empty[0], 1'b1);
        tick();

        // Burst of three, each load 2 cycles after done_tx
        wr(0, 8'hA5);
        chk("burst.level1", level[0], 5'd1);
        wr(0, 8'h5A);
        chk("burst.du1", data_update[0], 1'b1);
        chk("burst.din1", din_tx[0], 8'hA5);
        chk("burst.level_load", level[0], 5'd1);
        wr(0, 8'hFF);
        chk("burst.level2", level[0], 5'd2);
        repeat (5) tick();
        done_pulse(0);
        chk("burst.no_du_d1", data_update[0], 1'b0);
        tick();
        chk("burst.du2", data_update[0], 1'b1);
        chk("burst.din2", din_tx[0], 8'h5A);
        chk("burst.level_after2", level[0], 5'd1);
        repeat (3) tick();
        done_pulse(0);
        tick();
        chk("burst.du3", data_update[0], 1'b1);
        chk("burst.din3", din_tx[0], 8'hFF);
        repeat (2) tick();
        done_pulse(0);
        tick();
        chk("burst.idle", busy[0], 1'b0);

        // Overflow: 17 writes fill the FIFO behind one outstanding byte
        for (int k = 0; k < 17; k++) wr(0, 8'(8'h10 + k));
        chk("ovf.full", full[0], 1'b1);
        chk("ovf.level16", level[0], 5'd16);
        wr(0, 8'hEE);
        chk("ovf.pulse", overflow[0], 1'b1);
        chk("ovf.level_kept", level[0], 5'd16);
        tick();
        chk("ovf.pulse_end", overflow[0], 1'b0);
        for (int k = 1; k < 17; k++) begin
            done_pulse(0);
            tick();
            chk("ovf.drain_du", data_update[0], 1'b1);
            chk("ovf.drain_din", din_tx[0], 8'(8'h10 + k));
            tick();
        end
        done_pulse(0);
        chk("ovf.drained", empty[0], 1'b1);
        chk("ovf.idle", busy[0], 1'b0);

        // Spurious done_tx while idle, then during LOAD
        done_pulse(0);
        chk("spur.no_du", data_update[0], 1'b0);
        chk("spur.idle", busy[0], 1'b0);
        tick();
        chk("spur.level", level[0], 5'd0);
        wr(0, 8'h3C);
        tick();
        chk("spur.load", data_update[0], 1'b1);
        done_pulse(0);
        tick();
        chk("spur.still_wait", busy[0], 1'b1);
        done_pulse(0);
        chk("spur.done_ok", busy[0], 1'b0);

        // Gap: second load 6 cycles after done_tx
        wr(1, 8'hB1);
        wr(1, 8'hB2);
        chk("gap.du1", data_update[1], 1'b1);
        chk("gap.din1", din_tx[1], 8'hB1);
        repeat (3) tick();
        done_pulse(1);
        chk("gap.busy_d1", busy[1], 1'b1);
        repeat (3) begin
            tick();
            chk("gap.no_du", data_update[1], 1'b0);
            chk("gap.busy_gap", busy[1], 1'b1);
        end
        tick();
        chk("gap.idle_d5", busy[1], 1'b0);
        tick();
        chk("gap.du2_d6", data_update[1], 1'b1);
        chk("gap.din2", din_tx[1], 8'hB2);

        // Reset while waiting with a byte still queued
        wr(1, 8'hC3);
        chk("rst.queued", level[1], 5'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.empty", empty[1], 1'b1);
        chk("rst.level", level[1], 5'd0);
        chk("rst.busy", busy[1], 1'b0);
        chk("rst.du", data_update[1], 1'b0);
        repeat (3) tick();
        chk("rst.no_du_later", data_update[1], 1'b0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // Timeout: 20 cycles in WAIT without done_tx
        wr(1, 8'h71);
        wr(1, 8'h72);
        chk("to.du1", data_update[1], 1'b1);
        repeat (20) tick();
        chk("to.not_yet", timeout[1], 1'b0);
        chk("to.busy", busy[1], 1'b1);
        tick();
        chk("to.pulse", timeout[1], 1'b1);
        chk("to.idle", busy[1], 1'b0);
        tick();
        chk("to.pulse_end", timeout[1], 1'b0);
        chk("to.du2", data_update[1], 1'b1);
        chk("to.din2", din_tx[1], 8'h72);
        done_pulse(1);
        repeat (8) tick();
        chk("to.final_idle", busy[1], 1'b0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
